// File: rtl/up_down_counter_mod.sv
// -----------------------------------------------------------------------------
// up_down_counter_mod
//
// General-purpose up/down counter over the range 0..MAX_COUNT (MAX_COUNT need
// not be a power of two). Supports count enable, synchronous parallel load
// with clamping, wrap or saturate at the range limits, a combinational
// terminal-count flag and a registered wrap/overflow pulse.
//
// Parameters:
//   WIDTH     - counter width in bits (>= 1)
//   MAX_COUNT - inclusive upper bound, 1 <= MAX_COUNT <= 2^WIDTH-1
//   SATURATE  - 0: wrap modulo MAX_COUNT+1, 1: hold at the limit
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous reset, active-low
//   en       in   count enable
//   mode     in   direction, 0 = up, 1 = down
//   load     in   synchronous load strobe (priority over en)
//   load_val in   value to load, clamped to MAX_COUNT
//   count    out  registered count
//   tc       out  terminal count (combinational from count and mode)
//   ovf      out  registered one-cycle pulse on wrap / step past a limit
// -----------------------------------------------------------------------------
module up_down_counter_mod #(
   parameter int unsigned WIDTH     = 3,
   parameter int unsigned MAX_COUNT = 7,
   parameter bit          SATURATE  = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);
   localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1);

   typedef enum logic [1:0] {
      ACT_HOLD,
      ACT_LOAD,
      ACT_UP,
      ACT_DOWN
   } act_e;

   act_e             act;
   logic [WIDTH-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             at_max, at_zero;

   assign at_max  = (count_q == MAX_C);
   assign at_zero = (count_q == '0);

   // Load outranks counting; reset is handled in the register process.
   always_comb begin
      act = ACT_HOLD;
      if (load) begin
         act = ACT_LOAD;
      end else if (en) begin
         act = mode ? ACT_DOWN : ACT_UP;
      end
   end

   // Limits are compared explicitly against MAX_COUNT / 0 so a range that
   // is not a power of two never relies on natural 2^WIDTH rollover.
   always_comb begin
      count_d = count_q;
      ovf_d   = 1'b0;
      case (act)
         ACT_LOAD: begin
            count_d = (load_val > MAX_C) ? MAX_C : load_val;
         end
         ACT_UP: begin
            if (at_max) begin
               ovf_d   = 1'b1;
               count_d = SATURATE ? MAX_C : '0;
            end else begin
               count_d = count_q + ONE_C;
            end
         end
         ACT_DOWN: begin
            if (at_zero) begin
               ovf_d   = 1'b1;
               count_d = SATURATE ? '0 : MAX_C;
            end else begin
               count_d = count_q - ONE_C;
            end
         end
         default: begin
            count_d = count_q;
            ovf_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   assign count = count_q;
   assign ovf   = ovf_q;
   assign tc    = mode ? at_zero : at_max;

endmodule

// File: tb/tb_up_down_counter_mod.sv
// -----------------------------------------------------------------------------
// tb_up_down_counter_mod
//
// Directed bench for up_down_counter_mod. Three instances share the control
// inputs: A (3-bit, max 7, wrap), B (4-bit, max 9, wrap), C (3-bit, max 7,
// saturate). Each task resets, drives its scenario and checks the instance
// that scenario targets against hand-computed values.
// -----------------------------------------------------------------------------
module tb_up_down_counter_mod;

   logic       clk;
   logic       rst, en, mode, load;
   logic [3:0] lv;
   logic [2:0] cnt_a, cnt_c;
   logic [3:0] cnt_b;
   logic       tc_a, tc_b, tc_c, ovf_a, ovf_b, ovf_c;

   int checks   = 0;
   int failures = 0;

   up_down_counter_mod #(.WIDTH(3), .MAX_COUNT(7), .SATURATE(1'b0)) u_a (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
      .load_val(lv[2:0]), .count(cnt_a), .tc(tc_a), .ovf(ovf_a));

   up_down_counter_mod #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b0)) u_b (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
      .load_val(lv), .count(cnt_b), .tc(tc_b), .ovf(ovf_b));

   up_down_counter_mod #(.WIDTH(3), .MAX_COUNT(7), .SATURATE(1'b1)) u_c (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
      .load_val(lv[2:0]), .count(cnt_c), .tc(tc_c), .ovf(ovf_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Advance one rising edge and settle outputs away from the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0; load = 1'b0; en = 1'b0; mode = 1'b0; lv = '0;
      step();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0; load = 1'b1; en = 1'b1; mode = 1'b0; lv = 4'd5;
      step();
      checks++;
      if (cnt_a !== 3'd0 || cnt_b !== 4'd0 || cnt_c !== 3'd0) begin
         failures++;
         $display("FAIL reset_count: got a=%0d b=%0d c=%0d expected 0", cnt_a, cnt_b, cnt_c);
      end
      checks++;
      if (ovf_a !== 1'b0 || ovf_b !== 1'b0 || ovf_c !== 1'b0) begin
         failures++;
         $display("FAIL reset_ovf: got a=%0b b=%0b c=%0b expected 0", ovf_a, ovf_b, ovf_c);
      end
      checks++;
      if (tc_a !== 1'b0) begin
         failures++;
         $display("FAIL reset_tc_up: got %0b expected 0", tc_a);
      end
      mode = 1'b1;
      #1;
      checks++;
      if (tc_a !== 1'b1) begin
         failures++;
         $display("FAIL reset_tc_down: got %0b expected 1", tc_a);
      end
      rst = 1'b1; load = 1'b0; en = 1'b0; mode = 1'b0;
   endtask

   task automatic test_up_wrap();
      int exp_c[10] = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2};
      do_reset();
      en = 1'b1; mode = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         checks++;
         if (cnt_a !== 3'(exp_c[i])) begin
            failures++;
            $display("FAIL up_wrap_count[%0d]: got %0d expected %0d", i, cnt_a, exp_c[i]);
         end
         checks++;
         if (ovf_a !== (i == 7)) begin
            failures++;
            $display("FAIL up_wrap_ovf[%0d]: got %0b expected %0b", i, ovf_a, (i == 7));
         end
         checks++;
         if (tc_a !== (exp_c[i] == 7)) begin
            failures++;
            $display("FAIL up_wrap_tc[%0d]: got %0b expected %0b", i, tc_a, (exp_c[i] == 7));
         end
      end
      en = 1'b0;
      step();
      checks++;
      if (cnt_a !== 3'd2 || ovf_a !== 1'b0) begin
         failures++;
         $display("FAIL up_wrap_hold: got count=%0d ovf=%0b expected count=2 ovf=0", cnt_a, ovf_a);
      end
   endtask

   task automatic test_down_wrap();
      int exp_c[11] = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 9};
      do_reset();
      en = 1'b1; mode = 1'b1;
      for (int i = 0; i < 11; i++) begin
         step();
         checks++;
         if (cnt_b !== 4'(exp_c[i])) begin
            failures++;
            $display("FAIL down_wrap_count[%0d]: got %0d expected %0d", i, cnt_b, exp_c[i]);
         end
         checks++;
         if (ovf_b !== (i == 0 || i == 10)) begin
            failures++;
            $display("FAIL down_wrap_ovf[%0d]: got %0b expected %0b", i, ovf_b, (i == 0 || i == 10));
         end
         checks++;
         if (tc_b !== (exp_c[i] == 0)) begin
            failures++;
            $display("FAIL down_wrap_tc[%0d]: got %0b expected %0b", i, tc_b, (exp_c[i] == 0));
         end
      end
   endtask

   task automatic test_saturate();
      int exp_c[5] = '{7, 7, 7, 6, 5};
      int exp_o[5] = '{0, 1, 1, 0, 0};
      do_reset();
      load = 1'b1; lv = 4'd6;
      step();
      checks++;
      if (cnt_c !== 3'd6 || ovf_c !== 1'b0) begin
         failures++;
         $display("FAIL sat_load: got count=%0d ovf=%0b expected count=6 ovf=0", cnt_c, ovf_c);
      end
      load = 1'b0; en = 1'b1; mode = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i == 3) mode = 1'b1;
         step();
         checks++;
         if (cnt_c !== 3'(exp_c[i])) begin
            failures++;
            $display("FAIL sat_count[%0d]: got %0d expected %0d", i, cnt_c, exp_c[i]);
         end
         checks++;
         if (ovf_c !== exp_o[i][0]) begin
            failures++;
            $display("FAIL sat_ovf[%0d]: got %0b expected %0d", i, ovf_c, exp_o[i]);
         end
      end
      // Saturate at zero: hold at 0 with ovf raised on every attempted step.
      do_reset();
      en = 1'b1; mode = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if (cnt_c !== 3'd0 || ovf_c !== 1'b1) begin
            failures++;
            $display("FAIL sat_zero[%0d]: got count=%0d ovf=%0b expected count=0 ovf=1", i, cnt_c, ovf_c);
         end
      end
   endtask

   task automatic test_load();
      int vals[4] = '{4, 13, 9, 10};
      int exp_c[4] = '{4, 9, 9, 9};
      do_reset();
      load = 1'b1; en = 1'b1; mode = 1'b0;
      for (int i = 0; i < 4; i++) begin
         lv = 4'(vals[i]);
         step();
         checks++;
         if (cnt_b !== 4'(exp_c[i]) || ovf_b !== 1'b0) begin
            failures++;
            $display("FAIL load[%0d]: got count=%0d ovf=%0b expected count=%0d ovf=0", i, cnt_b, ovf_b, exp_c[i]);
         end
      end
      load = 1'b0; en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (cnt_b !== 4'd9 || ovf_b !== 1'b0) begin
            failures++;
            $display("FAIL load_hold[%0d]: got count=%0d ovf=%0b expected count=9 ovf=0", i, cnt_b, ovf_b);
         end
      end
   endtask

   task automatic test_reversal_and_reset();
      do_reset();
      en = 1'b1; mode = 1'b0;
      repeat (5) step();
      checks++;
      if (cnt_a !== 3'd5) begin
         failures++;
         $display("FAIL rev_up5: got %0d expected 5", cnt_a);
      end
      mode = 1'b1;
      step();
      checks++;
      if (cnt_a !== 3'd4 || ovf_a !== 1'b0) begin
         failures++;
         $display("FAIL rev_down: got count=%0d ovf=%0b expected count=4 ovf=0", cnt_a, ovf_a);
      end
      // tc follows mode without a clock edge.
      en = 1'b0; load = 1'b1; lv = 4'd7;
      step();
      load = 1'b0; mode = 1'b0;
      #1;
      checks++;
      if (tc_a !== 1'b1) begin
         failures++;
         $display("FAIL tc_comb_up: got %0b expected 1", tc_a);
      end
      mode = 1'b1;
      #1;
      checks++;
      if (tc_a !== 1'b0) begin
         failures++;
         $display("FAIL tc_comb_down: got %0b expected 0", tc_a);
      end
      rst = 1'b0; load = 1'b1; lv = 4'd3; en = 1'b1;
      step();
      checks++;
      if (cnt_a !== 3'd0 || ovf_a !== 1'b0) begin
         failures++;
         $display("FAIL rst_over_load: got count=%0d ovf=%0b expected count=0 ovf=0", cnt_a, ovf_a);
      end
      rst = 1'b1; load = 1'b0; mode = 1'b1;
      step();
      checks++;
      if (cnt_a !== 3'd7 || ovf_a !== 1'b1) begin
         failures++;
         $display("FAIL resume_down: got count=%0d ovf=%0b expected count=7 ovf=1", cnt_a, ovf_a);
      end
      step();
      checks++;
      if (cnt_a !== 3'd6 || ovf_a !== 1'b0) begin
         failures++;
         $display("FAIL resume_down2: got count=%0d ovf=%0b expected count=6 ovf=0", cnt_a, ovf_a);
      end
   endtask

   initial begin
      rst = 1'b0; en = 1'b0; mode = 1'b0; load = 1'b0; lv = '0;
      #2;
      test_reset();
      test_up_wrap();
      test_down_wrap();
      test_saturate();
      test_load();
      test_reversal_and_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
